// File: rtl/stream_frame_arbiter.sv
// Frame-locked round-robin arbiter: shares one valid/ready/eof sink between up to
// four sources, holding each grant until eof and aborting sources that stall mid-frame.
module stream_frame_arbiter #(
   parameter int N_SRC   = 4,
   parameter int DW      = 32,
   parameter int TIMEOUT = 256
) (
   input  logic                   clk,
   input  logic                   rstb,
   input  logic [N_SRC-1:0]       en_mask,
   input  logic [N_SRC-1:0]       in_valid,
   input  logic [N_SRC*DW-1:0]    in_data,
   input  logic [N_SRC-1:0]       in_eof,
   output logic [N_SRC-1:0]       in_ready,
   output logic                   out_valid,
   output logic [DW-1:0]          dout,
   output logic                   out_eof,
   input  logic                   out_ready,
   output logic [1:0]             out_src,
   output logic                   busy,
   output logic [15:0]            frame_cnt,
   output logic                   timeout_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   state_t          state;
   logic [1:0]      gnt;
   logic [1:0]      last_gnt;
   logic [CW-1:0]   idle_cnt;

   logic [N_SRC-1:0] req;
   logic             pick_vld;
   logic [1:0]       pick;
   logic [2:0]       cand;

   logic             sel_valid;
   logic             sel_eof;
   logic [DW-1:0]    sel_data;

   assign req = in_valid & en_mask;

   // Round-robin search starting just after the last granted source, wrapping at N_SRC.
   always_comb begin
      pick_vld = 1'b0;
      pick     = '0;
      cand     = '0;
      for (int i = 1; i <= N_SRC; i++) begin
         cand = {1'b0, last_gnt} + 3'(i);
         if (cand >= 3'(N_SRC)) begin
            cand = cand - 3'(N_SRC);
         end
         if (!pick_vld && req[cand[1:0]]) begin
            pick_vld = 1'b1;
            pick     = cand[1:0];
         end
      end
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_eof   = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (gnt == 2'(i)) begin
            sel_valid = in_valid[i];
            sel_eof   = in_eof[i];
            sel_data  = in_data[i*DW +: DW];
         end
      end
   end

   // Unbuffered pass-through of the granted source; everything is quiet in IDLE.
   always_comb begin
      out_valid = (state == STREAM) && sel_valid;
      out_eof   = (state == STREAM) && sel_eof;
      dout      = (state == STREAM) ? sel_data : '0;
      in_ready  = '0;
      for (int i = 0; i < N_SRC; i++) begin
         in_ready[i] = (state == STREAM) && (gnt == 2'(i)) && out_ready;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state       <= IDLE;
         gnt         <= '0;
         last_gnt    <= 2'(N_SRC - 1);
         idle_cnt    <= '0;
         frame_cnt   <= '0;
         out_src     <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  gnt      <= pick;
                  out_src  <= pick;
                  idle_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= STREAM;
               end
            end
            STREAM: begin
               // The abort cycle wins over anything the source offers in that same cycle.
               if (idle_cnt == CW'(TIMEOUT)) begin
                  last_gnt <= gnt;
                  idle_cnt <= '0;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else if (out_valid && out_ready && out_eof) begin
                  frame_cnt <= frame_cnt + 16'd1;
                  last_gnt  <= gnt;
                  idle_cnt  <= '0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else if (sel_valid) begin
                  idle_cnt <= '0;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
                  if (idle_cnt == CW'(TIMEOUT - 1)) begin
                     timeout_err <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stream_frame_arbiter.sv
// Directed bench for stream_frame_arbiter: source queues feed the DUT, a negedge
// monitor pops the expected-beat scoreboard on every accepted sink beat.
module tb_stream_frame_arbiter;

   localparam int NS = 4;
   localparam int W  = 32;
   localparam int TO = 8;

   typedef struct packed {
      logic [1:0]  src;
      logic [31:0] data;
      logic        eof;
   } beat_t;

   logic            clk = 1'b0;
   logic            rstb;
   logic [NS-1:0]   en_mask;
   logic [NS-1:0]   in_valid;
   logic [NS*W-1:0] in_data;
   logic [NS-1:0]   in_eof;
   logic [NS-1:0]   in_ready;
   logic            out_valid;
   logic [W-1:0]    dout;
   logic            out_eof;
   logic            out_ready;
   logic [1:0]      out_src;
   logic            busy;
   logic [15:0]     frame_cnt;
   logic            timeout_err;

   beat_t       expq[$];
   logic [32:0] srcq[NS][$];
   int          beat_cyc[$];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   stream_frame_arbiter #(.N_SRC(NS), .DW(W), .TIMEOUT(TO)) dut (
      .clk(clk),
      .rstb(rstb),
      .en_mask(en_mask),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_eof(in_eof),
      .in_ready(in_ready),
      .out_valid(out_valid),
      .dout(dout),
      .out_eof(out_eof),
      .out_ready(out_ready),
      .out_src(out_src),
      .busy(busy),
      .frame_cnt(frame_cnt),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   // Scoreboard monitor: every beat the sink accepts must match the head of expq.
   always @(negedge clk) begin
      if (rstb && out_valid && out_ready) begin
         if (expq.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_beat: got src=%0d data=%h want no beat", out_src, dout);
         end else begin
            beat_t e;
            e = expq.pop_front();
            check_output("beat_data", dout, e.data);
            check_output("beat_src", 32'(out_src), 32'(e.src));
            check_output("beat_eof", 32'(out_eof), 32'(e.eof));
            beat_cyc.push_back(cyc);
         end
      end
   end

   task automatic refresh_src();
      logic [32:0] h;
      for (int i = 0; i < NS; i++) begin
         if (srcq[i].size() > 0) begin
            h = srcq[i][0];
            in_valid[i]       = 1'b1;
            in_data[i*W +: W] = h[31:0];
            in_eof[i]         = h[32];
         end else begin
            in_valid[i]       = 1'b0;
            in_data[i*W +: W] = '0;
            in_eof[i]         = 1'b0;
         end
      end
   endtask

   // One clock: sample handshakes at negedge, advance source queues just after posedge.
   task automatic tick();
      logic [NS-1:0] fire;
      @(negedge clk);
      fire = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
         if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      end
      refresh_src();
   endtask

   task automatic apply_stimulus(input int src, input int base, input int n, input logic last_eof,
                                 input logic expect_it);
      beat_t e;
      for (int k = 0; k < n; k++) begin
         srcq[src].push_back({(k == n - 1) ? last_eof : 1'b0, 32'(base + k)});
         if (expect_it) begin
            e.src  = 2'(src);
            e.data = 32'(base + k);
            e.eof  = (k == n - 1) ? last_eof : 1'b0;
            expq.push_back(e);
         end
      end
   endtask

   task automatic wait_drain(input int limit);
      int n = 0;
      while (expq.size() > 0 && n < limit) begin
         tick();
         n++;
      end
      check_output("drain_left", 32'(expq.size()), 32'd0);
      expq.delete();
   endtask

   task automatic do_reset();
      rstb = 1'b0;
      for (int i = 0; i < NS; i++) srcq[i].delete();
      refresh_src();
      tick();
      tick();
      rstb = 1'b1;
   endtask

   initial begin
      rstb      = 1'b0;
      en_mask   = '0;
      out_ready = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      in_eof    = '0;
      tick();
      tick();
      check_output("rst_out_valid", 32'(out_valid), 32'd0);
      check_output("rst_in_ready", 32'(in_ready), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check_output("rst_out_src", 32'(out_src), 32'd0);
      check_output("rst_timeout", 32'(timeout_err), 32'd0);
      check_output("rst_dout", dout, 32'd0);
      rstb = 1'b1;
      tick();

      // Single source, 4-beat frame in back-to-back cycles.
      en_mask = 4'b0001;
      beat_cyc.delete();
      apply_stimulus(0, 1, 4, 1'b1, 1'b1);
      tick();
      wait_drain(20);
      check_output("t1_busy_after_eof", 32'(busy), 32'd0);
      check_output("t1_frame_cnt", 32'(frame_cnt), 32'd1);
      check_output("t1_beats", 32'(beat_cyc.size()), 32'd4);
      if (beat_cyc.size() == 4) check_output("t1_span", 32'(beat_cyc[3] - beat_cyc[0]), 32'd3);

      // All four requesting: order 0,1,2,3,0 with one bubble between frames.
      do_reset();
      en_mask = 4'b1111;
      beat_cyc.delete();
      apply_stimulus(0, 'hA0, 2, 1'b1, 1'b1);
      apply_stimulus(1, 'hB0, 2, 1'b1, 1'b1);
      apply_stimulus(2, 'hC0, 2, 1'b1, 1'b1);
      apply_stimulus(3, 'hD0, 2, 1'b1, 1'b1);
      apply_stimulus(0, 'hE0, 2, 1'b1, 1'b1);
      tick();
      wait_drain(40);
      check_output("t2_frame_cnt", 32'(frame_cnt), 32'd5);
      check_output("t2_beats", 32'(beat_cyc.size()), 32'd10);
      if (beat_cyc.size() == 10) check_output("t2_span", 32'(beat_cyc[9] - beat_cyc[0]), 32'd13);

      // Sink backpressure toggling: in_ready[1] follows out_ready, no timeout.
      en_mask = 4'b0010;
      apply_stimulus(1, 'h11, 5, 1'b1, 1'b1);
      tick();
      for (int k = 0; k < 10; k++) begin
         tick();
         out_ready = (k % 2 == 0);
         #2;
         check_output("t3_in_ready", 32'(in_ready),
                      (k < 9 && (k % 2 == 0)) ? 32'h2 : 32'h0);
         check_output("t3_timeout", 32'(timeout_err), 32'd0);
      end
      out_ready = 1'b1;
      check_output("t3_left", 32'(expq.size()), 32'd0);
      check_output("t3_frame_cnt", 32'(frame_cnt), 32'd6);

      // Source 2 stalls after one beat: abort 8 cycles after valid drops, then source 3.
      en_mask = 4'b1100;
      apply_stimulus(2, 'h21, 1, 1'b0, 1'b1);
      apply_stimulus(3, 'h31, 2, 1'b1, 1'b1);
      tick();
      tick();
      for (int j = 2; j <= 11; j++) begin
         tick();
         check_output("t4_timeout_pulse", 32'(timeout_err), (j == 10) ? 32'd1 : 32'd0);
      end
      check_output("t4_frame_cnt_abort", 32'(frame_cnt), 32'd6);
      wait_drain(20);
      check_output("t4_frame_cnt", 32'(frame_cnt), 32'd7);

      // Mask source 0 mid-frame: its frame finishes, its next frame is never granted.
      en_mask = 4'b0001;
      apply_stimulus(0, 'h51, 4, 1'b1, 1'b1);
      apply_stimulus(0, 'h55, 1, 1'b1, 1'b0);
      apply_stimulus(1, 'h61, 1, 1'b1, 1'b1);
      tick();
      tick();
      en_mask = 4'b0010;
      wait_drain(40);
      for (int k = 0; k < 6; k++) tick();
      check_output("t5_busy", 32'(busy), 32'd0);
      check_output("t5_frame_cnt", 32'(frame_cnt), 32'd9);
      srcq[0].delete();
      tick();

      // Reset mid-frame of source 1 while the sink stalls; source 0 wins after release.
      en_mask   = 4'b0010;
      out_ready = 1'b0;
      apply_stimulus(1, 'h91, 3, 1'b1, 1'b0);
      tick();
      for (int k = 0; k < 12; k++) begin
         tick();
         check_output("t6_no_timeout", 32'(timeout_err), 32'd0);
      end
      check_output("t6_out_valid_pre", 32'(out_valid), 32'd1);
      check_output("t6_src_pre", 32'(out_src), 32'd1);
      rstb = 1'b0;
      #1;
      check_output("t6_out_valid_rst", 32'(out_valid), 32'd0);
      check_output("t6_in_ready_rst", 32'(in_ready), 32'd0);
      check_output("t6_frame_cnt_rst", 32'(frame_cnt), 32'd0);
      check_output("t6_busy_rst", 32'(busy), 32'd0);
      srcq[1].delete();
      en_mask   = 4'b0011;
      out_ready = 1'b1;
      apply_stimulus(0, 'hA5, 1, 1'b1, 1'b1);
      apply_stimulus(1, 'hB5, 1, 1'b1, 1'b1);
      refresh_src();
      tick();
      rstb = 1'b1;
      wait_drain(20);
      check_output("t6_frame_cnt", 32'(frame_cnt), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
